// File: rtl/encoder_level.sv
// Rotary encoder front end: synchronises and debounces quadrature inputs, decodes x1 detents
// and keeps a saturating level for the PWM stage. Define ENCODER_ACCEL_EN to enable step acceleration.
module encoder_level #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP            = 1,
    parameter int INIT            = 0,
    parameter int ACCEL_WINDOW    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] level,
    output logic             changed
);

    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = WIDTH + 3;
    localparam logic [CW-1:0]    DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW-1:0]    MAX_LEVEL  = {3'b000, {WIDTH{1'b1}}};
    localparam logic [AW-1:0]    STEP_BASE  = AW'(STEP);
    localparam logic [WIDTH-1:0] INIT_LEVEL = WIDTH'(INIT);

    logic [1:0] raw;
    logic [1:0] deb;
    logic [1:0] deb_prev_reg;

    assign raw = {b, a};

    // Channel 0 is A, channel 1 is B; each gets its own synchroniser and debouncer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic          sync1_reg;
            logic          sync2_reg;
            logic          deb_reg;
            logic [CW-1:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev_reg <= 2'b00;
        end else begin
            deb_prev_reg <= deb;
        end
    end

    logic a_rise;
    logic b_flip;
    logic step_valid;
    logic dir_up;

    // Simultaneous A and B flips are ambiguous, so they only update the reference.
    assign a_rise     = deb[0] & ~deb_prev_reg[0];
    assign b_flip     = deb[1] ^ deb_prev_reg[1];
    assign step_valid = a_rise & ~b_flip;
    assign dir_up     = ~deb[1];

    logic [AW-1:0] step_amt;

`ifdef ENCODER_ACCEL_EN
    localparam int SW = $clog2(ACCEL_WINDOW + 1);
    localparam logic [SW-1:0] WIN = SW'(ACCEL_WINDOW);

    logic [SW-1:0] since_step_reg;
    logic          dir_prev_reg;
    logic          fast;

    assign fast     = (since_step_reg < WIN) && (dir_up == dir_prev_reg);
    assign step_amt = fast ? (STEP_BASE << 2) : STEP_BASE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            since_step_reg <= WIN;
            dir_prev_reg   <= 1'b1;
        end else if (step_valid) begin
            since_step_reg <= '0;
            dir_prev_reg   <= dir_up;
        end else if (since_step_reg < WIN) begin
            since_step_reg <= since_step_reg + 1'b1;
        end
    end
`else
    assign step_amt = STEP_BASE;
`endif

    logic [WIDTH-1:0] level_reg;
    logic             changed_reg;
    logic [AW-1:0]    level_ext;
    logic [AW-1:0]    sum_ext;
    logic [AW-1:0]    next_ext;
    logic             level_moves;

    assign level_ext = {3'b000, level_reg};
    assign sum_ext   = level_ext + step_amt;

    always_comb begin
        next_ext = level_ext;
        if (dir_up) begin
            next_ext = (sum_ext > MAX_LEVEL) ? MAX_LEVEL : sum_ext;
        end else begin
            next_ext = (level_ext < step_amt) ? '0 : (level_ext - step_amt);
        end
    end

    assign level_moves = step_valid && (next_ext != level_ext);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg   <= INIT_LEVEL;
            changed_reg <= 1'b0;
        end else begin
            changed_reg <= level_moves;
            if (level_moves) begin
                level_reg <= next_ext[WIDTH-1:0];
            end
        end
    end

    assign level   = level_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_encoder_level.sv
// Directed bench for encoder_level: three instances (default, STEP=16/INIT=250, INIT=10) share stimulus.
module tb_encoder_level;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [7:0] level0, level1, level2;
    logic       changed0, changed1, changed2;

    int pass_cnt = 0;
    int total_cnt = 0;
    int pc0 = 0, pc1 = 0, pc2 = 0;

    always #5 clk = ~clk;

    encoder_level dut0 (
        .clk(clk), .reset(reset), .a(a), .b(b), .level(level0), .changed(changed0)
    );

    encoder_level #(.STEP(16), .INIT(250)) dut1 (
        .clk(clk), .reset(reset), .a(a), .b(b), .level(level1), .changed(changed1)
    );

    encoder_level #(.INIT(10)) dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .level(level2), .changed(changed2)
    );

    always @(negedge clk) begin
        if (changed0 === 1'b1) pc0 <= pc0 + 1;
        if (changed1 === 1'b1) pc1 <= pc1 + 1;
        if (changed2 === 1'b1) pc2 <= pc2 + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        a = 1'b0;
        b = 1'b0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // One full detent: settle B, raise A, drop A.
    task automatic detent(input logic dir_b);
        b = dir_b;
        tick(8);
        a = 1'b1;
        tick(10);
        a = 1'b0;
        tick(10);
    endtask

    task automatic test_reset();
        int p0;
        tick(3);
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL reset_level0 got=%0d want=0", level0);
        else pass_cnt++;
        total_cnt++;
        if (changed0 !== 1'b0) $display("FAIL reset_changed0 got=%b want=0", changed0);
        else pass_cnt++;
        total_cnt++;
        if (level1 !== 8'd250) $display("FAIL reset_level1 got=%0d want=250", level1);
        else pass_cnt++;
        reset = 1'b0;
        p0 = pc0;
        tick(100);
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL idle_level0 got=%0d want=0", level0);
        else pass_cnt++;
        total_cnt++;
        if (pc0 - p0 !== 0) $display("FAIL idle_pulses got=%0d want=0", pc0 - p0);
        else pass_cnt++;
        $display("test_reset: level0=%0d level1=%0d pulses=%0d", level0, level1, pc0 - p0);
    endtask

    task automatic test_clean_cw();
        int p0;
        pulse_reset();
        p0 = pc0;
        a = 1'b1;
        tick(6);
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL clean_edge6_level got=%0d want=0", level0);
        else pass_cnt++;
        total_cnt++;
        if (pc0 - p0 !== 0) $display("FAIL clean_early_pulse got=%0d want=0", pc0 - p0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (level0 !== 8'd1) $display("FAIL clean_edge7_level got=%0d want=1", level0);
        else pass_cnt++;
        total_cnt++;
        if (changed0 !== 1'b1) $display("FAIL clean_edge7_changed got=%b want=1", changed0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (changed0 !== 1'b0) $display("FAIL clean_edge8_changed got=%b want=0", changed0);
        else pass_cnt++;
        a = 1'b0;
        tick(12);
        total_cnt++;
        if (level0 !== 8'd1) $display("FAIL clean_afall_level got=%0d want=1", level0);
        else pass_cnt++;
        total_cnt++;
        if (pc0 - p0 !== 1) $display("FAIL clean_pulses got=%0d want=1", pc0 - p0);
        else pass_cnt++;
        $display("test_clean_cw: level0=%0d pulses=%0d", level0, pc0 - p0);
    endtask

    task automatic test_saturation();
        int p0, p1;
        pulse_reset();
        p1 = pc1;
        detent(1'b0);
        total_cnt++;
        if (level1 !== 8'd255) $display("FAIL sat_hi_level got=%0d want=255", level1);
        else pass_cnt++;
        total_cnt++;
        if (pc1 - p1 !== 1) $display("FAIL sat_hi_pulses got=%0d want=1", pc1 - p1);
        else pass_cnt++;
        p1 = pc1;
        detent(1'b0);
        total_cnt++;
        if (level1 !== 8'd255) $display("FAIL sat_hold_level got=%0d want=255", level1);
        else pass_cnt++;
        total_cnt++;
        if (pc1 - p1 !== 0) $display("FAIL sat_hold_pulses got=%0d want=0", pc1 - p1);
        else pass_cnt++;
        $display("test_saturation hi: level1=%0d", level1);

        pulse_reset();
        p0 = pc0;
        p1 = pc1;
        detent(1'b1);
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL sat_lo_level got=%0d want=0", level0);
        else pass_cnt++;
        total_cnt++;
        if (pc0 - p0 !== 0) $display("FAIL sat_lo_pulses got=%0d want=0", pc0 - p0);
        else pass_cnt++;
        total_cnt++;
        if (level1 !== 8'd234) $display("FAIL ccw_step16_level got=%0d want=234", level1);
        else pass_cnt++;
        total_cnt++;
        if (pc1 - p1 !== 1) $display("FAIL ccw_step16_pulses got=%0d want=1", pc1 - p1);
        else pass_cnt++;
        b = 1'b0;
        tick(10);
        $display("test_saturation lo: level0=%0d level1=%0d", level0, level1);
    endtask

    task automatic test_bounce();
        int p0;
        pulse_reset();
        p0 = pc0;
        repeat (2) begin
            a = 1'b1;
            tick(2);
            a = 1'b0;
            tick(2);
        end
        a = 1'b1;
        tick(20);
        total_cnt++;
        if (level0 !== 8'd1) $display("FAIL bounce_level got=%0d want=1", level0);
        else pass_cnt++;
        total_cnt++;
        if (pc0 - p0 !== 1) $display("FAIL bounce_pulses got=%0d want=1", pc0 - p0);
        else pass_cnt++;
        a = 1'b0;
        tick(10);
        $display("test_bounce: level0=%0d pulses=%0d", level0, pc0 - p0);
    endtask

    task automatic test_accel();
        logic [7:0] exp1, exp2, exp3, exp4;
`ifdef ENCODER_ACCEL_EN
        exp1 = 8'd11; exp2 = 8'd15; exp3 = 8'd16; exp4 = 8'd15;
`else
        exp1 = 8'd11; exp2 = 8'd12; exp3 = 8'd13; exp4 = 8'd12;
`endif
        pulse_reset();
        detent(1'b0);
        total_cnt++;
        if (level2 !== exp1) $display("FAIL accel_first got=%0d want=%0d", level2, exp1);
        else pass_cnt++;
        tick(72);
        detent(1'b0);
        total_cnt++;
        if (level2 !== exp2) $display("FAIL accel_second got=%0d want=%0d", level2, exp2);
        else pass_cnt++;
        tick(2000);
        detent(1'b0);
        total_cnt++;
        if (level2 !== exp3) $display("FAIL accel_slow got=%0d want=%0d", level2, exp3);
        else pass_cnt++;
        detent(1'b1);
        total_cnt++;
        if (level2 !== exp4) $display("FAIL accel_reverse got=%0d want=%0d", level2, exp4);
        else pass_cnt++;
        b = 1'b0;
        tick(10);
        $display("test_accel: level2=%0d", level2);
    endtask

    task automatic test_reset_mid();
        int p0;
        pulse_reset();
        detent(1'b0);
        total_cnt++;
        if (level0 !== 8'd1) $display("FAIL mid_pre_level got=%0d want=1", level0);
        else pass_cnt++;
        a = 1'b1;
        tick(3);
        p0 = pc0;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL mid_async_level0 got=%0d want=0", level0);
        else pass_cnt++;
        total_cnt++;
        if (level2 !== 8'd10) $display("FAIL mid_async_level2 got=%0d want=10", level2);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (pc0 - p0 !== 0) $display("FAIL mid_reset_pulses got=%0d want=0", pc0 - p0);
        else pass_cnt++;
        reset = 1'b0;
        tick(6);
        total_cnt++;
        if (level0 !== 8'd0) $display("FAIL mid_edge6_level got=%0d want=0", level0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (level0 !== 8'd1 || changed0 !== 1'b1)
            $display("FAIL mid_edge7 level=%0d changed=%b want level=1 changed=1", level0, changed0);
        else pass_cnt++;
        tick(20);
        total_cnt++;
        if (pc0 - p0 !== 1) $display("FAIL mid_total_pulses got=%0d want=1", pc0 - p0);
        else pass_cnt++;
        a = 1'b0;
        tick(10);
        $display("test_reset_mid: level0=%0d pulses=%0d", level0, pc0 - p0);
    endtask

    initial begin
        test_reset();
        test_clean_cw();
        test_saturation();
        test_bounce();
        test_accel();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
